// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, PC reset value and the next-PC select encoding.
package cpu_pkg;

  localparam int ADDR_W = 12;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t PC_RESET = '0;

  typedef enum logic [1:0] {
    SEQ = 2'b00,
    JMP = 2'b01,
    RET = 2'b10,
    BR  = 2'b11
  } pc_src_e;

endpackage

// File: rtl/ret_lifo.sv
// Return-address LIFO: storage, occupancy count, push/pop/replace rules, and
// single-cycle overflow/underflow pulses for the parent's sticky error flag.
module ret_lifo #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          wdata,
  output logic [ADDR_W-1:0]          tos,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;
  logic              do_push;
  logic              do_pop;
  logic              do_repl;

  assign wr_idx  = cnt[AW-1:0];
  assign top_idx = AW'(cnt - CW'(1));

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Push+pop on a non-empty stack rewrites the top in place (tail call style).
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign do_repl = push & pop & ~empty;

  assign ovf = push & ~pop & full;
  assign unf = pop & empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CW'(1);
    end else if (do_pop) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Storage carries no reset; entries above count are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= wdata;
    end else if (do_repl) begin
      mem[top_idx] <= wdata;
    end
  end

  assign tos   = empty ? '0 : mem[top_idx];
  assign count = cnt;

endmodule

// File: rtl/pc_ret_stack.sv
// Program counter with hardware return-address stack.
// Optional PC_RET_STACK_HALT_EN: a stack error freezes the PC until err_clr.
module pc_ret_stack
  import cpu_pkg::PC_RESET;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_we,
  input  logic [ADDR_W-1:0]      next_pc,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   err_clr,
  output logic [ADDR_W-1:0]      pc,
  output logic [ADDR_W-1:0]      pc_plus1,
  output logic [ADDR_W-1:0]      tos,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   stack_err,
  output logic                   halted
);

  logic ovf;
  logic unf;
  logic pc_load;

  assign pc_plus1 = pc + ADDR_W'(1);

  ret_lifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wdata  (pc_plus1),
    .tos    (tos),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .unf    (unf)
  );

`ifdef PC_RET_STACK_HALT_EN
  assign pc_load = pc_we & ~stack_err;
  assign halted  = stack_err;
`else
  assign pc_load = pc_we;
  assign halted  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= ADDR_W'(PC_RESET);
    end else if (pc_load) begin
      pc <= next_pc;
    end
  end

  // A fresh error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_err <= 1'b0;
    end else if (ovf | unf) begin
      stack_err <= 1'b1;
    end else if (err_clr) begin
      stack_err <= 1'b0;
    end
  end

endmodule
